// File: rtl/reset_sequencer_if.sv
// Soft-reset request/ack and per-domain reset bundle for reset_sequencer.
// soft_cnt exists only when RST_SEQ_SOFT_COUNT_EN is defined.
interface reset_sequencer_if #(
  parameter int N_STAGES = 3
);
  logic                soft_req;
  logic [N_STAGES-1:0] soft_mask;
  logic                soft_ack;
  logic [N_STAGES-1:0] stage_rst;
  logic                all_ready;
  logic [1:0]          state_o;
`ifdef RST_SEQ_SOFT_COUNT_EN
  logic [7:0]          soft_cnt;

  // master = soft-reset requester / reset consumer, slave = sequencer
  modport master (
    output soft_req, soft_mask,
    input  soft_ack, stage_rst, all_ready, state_o, soft_cnt
  );
  modport slave (
    input  soft_req, soft_mask,
    output soft_ack, stage_rst, all_ready, state_o, soft_cnt
  );
`else
  modport master (
    output soft_req, soft_mask,
    input  soft_ack, stage_rst, all_ready, state_o
  );
  modport slave (
    input  soft_req, soft_mask,
    output soft_ack, stage_rst, all_ready, state_o
  );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Staged per-domain reset release with soft re-reset of a stage subset.
// Optional completed-request counter enabled by RST_SEQ_SOFT_COUNT_EN.
module reset_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 1000,
  parameter int CNT_W       = 24
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  reset_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_SOFT    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic [N_STAGES-1:0] pend_q, pend_d;
  logic                first_q, first_d;
  logic                ack_q, ack_d;
  logic [N_STAGES-1:0] rel_low, pend_low;

  // Lowest set bit: next stage to release in power-up and soft sequences.
  assign rel_low  = stage_rst_q & (~stage_rst_q + N_STAGES'(1));
  assign pend_low = pend_q & (~pend_q + N_STAGES'(1));

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      stage_rst_q <= '1;
      pend_q      <= '0;
      first_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_rst_q <= stage_rst_d;
      pend_q      <= pend_d;
      first_q     <= first_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_rst_d = stage_rst_q;
    pend_d      = pend_q;
    first_d     = first_q;
    ack_d       = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          stage_rst_d = stage_rst_q & ~rel_low;
          cnt_d       = '0;
          state_d     = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (stage_rst_q == '0) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == GAP_LAST) begin
          stage_rst_d = stage_rst_q & ~rel_low;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Blocking on ack_q gives the requester one cycle to drop soft_req.
        if (bus.soft_req && !ack_q) begin
          if (bus.soft_mask == '0) begin
            ack_d = 1'b1;
          end else begin
            pend_d      = bus.soft_mask;
            stage_rst_d = stage_rst_q | bus.soft_mask;
            first_d     = 1'b1;
            cnt_d       = '0;
            state_d     = S_SOFT;
          end
        end
      end
      S_SOFT: begin
        if (pend_q == '0) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_q == (first_q ? HOLD_LAST : GAP_LAST)) begin
          stage_rst_d = stage_rst_q & ~pend_low;
          pend_d      = pend_q & ~pend_low;
          first_d     = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign bus.stage_rst = stage_rst_q;
  assign bus.soft_ack  = ack_q;
  assign bus.all_ready = (state_q == S_RUN);
  assign bus.state_o   = state_q;

`ifdef RST_SEQ_SOFT_COUNT_EN
  logic [7:0] soft_cnt_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst)                               soft_cnt_q <= '0;
    else if (ack_d && soft_cnt_q != 8'hFF) soft_cnt_q <= soft_cnt_q + 8'd1;
  end

  assign bus.soft_cnt = soft_cnt_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random
// stimulus against an event-time reference model.
module tb_reset_sequencer;
  localparam int N = 3;
  localparam int H = 4;
  localparam int G = 8;
  localparam int M_PWR  = 0;
  localparam int M_RUN  = 1;
  localparam int M_SOFT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  reset_sequencer_if #(.N_STAGES(N)) bus ();

  reset_sequencer #(.N_STAGES(N), .HOLD_CYCLES(H), .STAGE_GAP(G), .CNT_W(8)) dut (
    .clk_100mhz (clk),
    .rst        (rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: release times computed from the sequencing rules.
  int           cyc     = 0;
  int           pw_base = 0;
  int           mode    = M_PWR;
  int           rel_t [N];
  int           done_t  = 0;
  logic [N-1:0] smask   = '0;
  logic         exp_ack = 1'b0;
  int           exp_cnt = 0;

  function automatic logic [N-1:0] m_rst();
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (mode == M_PWR)       r[i] = (cyc - pw_base) < (H + i * G);
      else if (mode == M_SOFT) r[i] = smask[i] && (cyc < rel_t[i]);
    end
    return r;
  endfunction

  function automatic logic [1:0] m_state();
    if (mode == M_PWR) return ((cyc - pw_base) < H) ? 2'd0 : 2'd1;
    if (mode == M_RUN) return 2'd2;
    return 2'd3;
  endfunction

  task automatic step();
    logic new_ack;
    int   t, last;
    @(posedge clk);
    cyc++;
    new_ack = 1'b0;
    if (rst) begin
      mode    = M_PWR;
      pw_base = cyc;
      exp_cnt = 0;
    end else begin
      case (mode)
        M_PWR: if ((cyc - pw_base) >= H + (N - 1) * G + 1) mode = M_RUN;
        M_RUN: if (bus.soft_req && !exp_ack) begin
          if (bus.soft_mask == '0) new_ack = 1'b1;
          else begin
            smask = bus.soft_mask;
            t     = cyc + H;
            last  = cyc;
            for (int i = 0; i < N; i++) begin
              rel_t[i] = 0;
              if (smask[i]) begin rel_t[i] = t; last = t; t = t + G; end
            end
            done_t = last + 1;
            mode   = M_SOFT;
          end
        end
        default: if (cyc == done_t) begin mode = M_RUN; new_ack = 1'b1; end
      endcase
    end
    exp_ack = new_ack;
    if (new_ack && exp_cnt < 255) exp_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.soft_req = 1'b0; bus.soft_mask = '0;
    repeat (3) step();
    n_chk++; if (bus.stage_rst !== 3'b111) begin n_fail++; $display("FAIL reset_stage_rst got %b want 111", bus.stage_rst); end
    n_chk++; if (bus.soft_ack !== 1'b0) begin n_fail++; $display("FAIL reset_soft_ack got %b want 0", bus.soft_ack); end
    n_chk++; if (bus.all_ready !== 1'b0) begin n_fail++; $display("FAIL reset_all_ready got %b want 0", bus.all_ready); end
    n_chk++; if (bus.state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state_o); end
  endtask

  task automatic test_powerup();
    rst = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      step();
      n_chk++; if (bus.stage_rst !== m_rst()) begin n_fail++; $display("FAIL pwr_model_rst edge %0d got %b want %b", e, bus.stage_rst, m_rst()); end
      if (e == 3) begin
        n_chk++; if (bus.stage_rst !== 3'b111 || bus.state_o !== 2'd0) begin n_fail++; $display("FAIL pwr_e3 got %b/%0d want 111/0", bus.stage_rst, bus.state_o); end
      end
      if (e == 4) begin
        n_chk++; if (bus.stage_rst !== 3'b110 || bus.state_o !== 2'd1) begin n_fail++; $display("FAIL pwr_e4 got %b/%0d want 110/1", bus.stage_rst, bus.state_o); end
      end
      if (e == 12) begin
        n_chk++; if (bus.stage_rst !== 3'b100) begin n_fail++; $display("FAIL pwr_e12 got %b want 100", bus.stage_rst); end
      end
      if (e == 20) begin
        n_chk++; if (bus.stage_rst !== 3'b000 || bus.all_ready !== 1'b0) begin n_fail++; $display("FAIL pwr_e20 got %b/%b want 000/0", bus.stage_rst, bus.all_ready); end
      end
      if (e == 21) begin
        n_chk++; if (bus.all_ready !== 1'b1 || bus.state_o !== 2'd2) begin n_fail++; $display("FAIL pwr_e21 got %b/%0d want 1/2", bus.all_ready, bus.state_o); end
      end
    end
  endtask

  task automatic test_soft_mask101();
    bus.soft_req = 1'b1; bus.soft_mask = 3'b101;
    step();
    n_chk++; if (bus.stage_rst !== 3'b101 || bus.state_o !== 2'd3 || bus.all_ready !== 1'b0) begin
      n_fail++; $display("FAIL soft_E got %b/%0d/%b want 101/3/0", bus.stage_rst, bus.state_o, bus.all_ready); end
    for (int k = 1; k <= 13; k++) begin
      step();
      n_chk++; if (bus.stage_rst[1] !== 1'b0) begin n_fail++; $display("FAIL soft_stage1 E+%0d got %b want 0", k, bus.stage_rst[1]); end
      if (k == 3) begin
        n_chk++; if (bus.stage_rst !== 3'b101) begin n_fail++; $display("FAIL soft_E3 got %b want 101", bus.stage_rst); end
      end
      if (k == 4 || k == 11) begin
        n_chk++; if (bus.stage_rst !== 3'b100) begin n_fail++; $display("FAIL soft_E%0d got %b want 100", k, bus.stage_rst); end
      end
      if (k == 12) begin
        n_chk++; if (bus.stage_rst !== 3'b000 || bus.soft_ack !== 1'b0 || bus.all_ready !== 1'b0) begin
          n_fail++; $display("FAIL soft_E12 got %b/%b/%b want 000/0/0", bus.stage_rst, bus.soft_ack, bus.all_ready); end
      end
      if (k == 13) begin
        n_chk++; if (bus.soft_ack !== 1'b1 || bus.all_ready !== 1'b1 || bus.state_o !== 2'd2) begin
          n_fail++; $display("FAIL soft_E13 got %b/%b/%0d want 1/1/2", bus.soft_ack, bus.all_ready, bus.state_o); end
      end
    end
    bus.soft_req = 1'b0;
    step();
    n_chk++; if (bus.soft_ack !== 1'b0) begin n_fail++; $display("FAIL soft_ack_width got %b want 0", bus.soft_ack); end
  endtask

  task automatic test_soft_zero();
    bus.soft_req = 1'b1; bus.soft_mask = 3'b000;
    step();
    n_chk++; if (bus.soft_ack !== 1'b1 || bus.stage_rst !== 3'b000 || bus.all_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_ack got %b/%b/%b want 1/000/1", bus.soft_ack, bus.stage_rst, bus.all_ready); end
    bus.soft_req = 1'b0;
    step();
    n_chk++; if (bus.soft_ack !== 1'b0 || bus.all_ready !== 1'b1 || bus.state_o !== 2'd2) begin
      n_fail++; $display("FAIL zero_after got %b/%b/%0d want 0/1/2", bus.soft_ack, bus.all_ready, bus.state_o); end
  endtask

  task automatic test_rst_mid_soft();
    bus.soft_req = 1'b1; bus.soft_mask = 3'b101;
    repeat (6) step();
    rst = 1'b1;
    step();
    n_chk++; if (bus.stage_rst !== 3'b111 || bus.all_ready !== 1'b0 || bus.soft_ack !== 1'b0 || bus.state_o !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid got %b/%b/%b/%0d want 111/0/0/0", bus.stage_rst, bus.all_ready, bus.soft_ack, bus.state_o); end
    bus.soft_req = 1'b0;
    test_powerup();
  endtask

  task automatic test_req_in_powerup();
    logic saw_ack;
    rst = 1'b1;
    step();
    rst = 1'b0; bus.soft_mask = 3'b011; saw_ack = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      if (e == 2) bus.soft_req = 1'b1;
      step();
      if (e == 18) bus.soft_req = 1'b0;
      if (bus.soft_ack !== 1'b0) saw_ack = 1'b1;
      n_chk++; if (bus.stage_rst !== m_rst()) begin n_fail++; $display("FAIL pwr_req_rst edge %0d got %b want %b", e, bus.stage_rst, m_rst()); end
    end
    n_chk++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL pwr_req_ack got 1 want 0"); end
    n_chk++; if (bus.stage_rst !== 3'b000 || bus.state_o !== 2'd2) begin
      n_fail++; $display("FAIL pwr_req_end got %b/%0d want 000/2", bus.stage_rst, bus.state_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) bus.soft_req = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) bus.soft_mask = N'($urandom_range(0, 7));
      step();
      n_chk++;
      if (bus.stage_rst !== m_rst() || bus.soft_ack !== exp_ack ||
          bus.all_ready !== (mode == M_RUN) || bus.state_o !== m_state()) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL rand cyc %0d got rst=%b ack=%b rdy=%b st=%0d want rst=%b ack=%b rdy=%b st=%0d",
                   c, bus.stage_rst, bus.soft_ack, bus.all_ready, bus.state_o,
                   m_rst(), exp_ack, (mode == M_RUN), m_state());
      end
`ifdef RST_SEQ_SOFT_COUNT_EN
      n_chk++; if (bus.soft_cnt !== 8'(exp_cnt)) begin
        n_fail++; if (n_fail < 30) $display("FAIL rand_cnt cyc %0d got %0d want %0d", c, bus.soft_cnt, exp_cnt); end
`endif
    end
    bus.soft_req = 1'b0; rst = 1'b0;
  endtask

`ifdef RST_SEQ_SOFT_COUNT_EN
  task automatic test_soft_cnt();
    int budget;
    rst = 1'b1; bus.soft_req = 1'b0;
    step();
    rst = 1'b0;
    budget = 0;
    while (bus.all_ready !== 1'b1 && budget < 40) begin step(); budget++; end
    n_chk++; if (bus.all_ready !== 1'b1) begin n_fail++; $display("FAIL cnt_ready timeout got %b want 1", bus.all_ready); end
    for (int r = 0; r < 3; r++) begin
      bus.soft_req = 1'b1; bus.soft_mask = (r == 1) ? 3'b010 : 3'b000;
      budget = 0;
      do begin step(); budget++; end while (bus.soft_ack !== 1'b1 && budget < 100);
      n_chk++; if (bus.soft_ack !== 1'b1) begin n_fail++; $display("FAIL cnt_ack timeout req %0d got 0 want 1", r); end
      bus.soft_req = 1'b0;
      step();
    end
    n_chk++; if (bus.soft_cnt !== 8'd3) begin n_fail++; $display("FAIL cnt_three got %0d want 3", bus.soft_cnt); end
    bus.soft_req = 1'b1; bus.soft_mask = 3'b000;
    repeat (600) step();
    bus.soft_req = 1'b0;
    step();
    n_chk++; if (bus.soft_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_sat got %0d want 255", bus.soft_cnt); end
    rst = 1'b1;
    step();
    n_chk++; if (bus.soft_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_rst got %0d want 0", bus.soft_cnt); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    bus.soft_req  = 1'b0;
    bus.soft_mask = '0;
    test_reset();
    test_powerup();
    test_soft_mask101();
    test_soft_zero();
    test_rst_mid_soft();
    test_req_in_powerup();
    test_random();
`ifdef RST_SEQ_SOFT_COUNT_EN
    test_soft_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
